hw_accel_unpack_rgb_gray: RTL and testbench

//  Inverse of the grayscale/RGB packer: accepts 32-bit packed words from the DMA/AXI-stream side and

---
 rtl/hw_accel_unpack_rgb_gray.sv | 120 ++++++++++++
 tb/tb_hw_accel_unpack_rgb_gray.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hw_accel_unpack_rgb_gray.sv
// Unpacks 32-bit DMA words into one pixel per cycle, tracking x/y and flagging end-of-line/end-of-frame.
// Build option: HW_ACCEL_UNPACK_GRAY_EXPAND_EN replicates each mode-2 gray sample onto R, G and B.

module hw_accel_unpack_rgb_gray_lane #(
  parameter int VEC_W = 8
) (
  input  logic [VEC_W-1:0]   gray,
  output logic [3*VEC_W-1:0] pixel
);
`ifdef HW_ACCEL_UNPACK_GRAY_EXPAND_EN
  assign pixel = {gray, gray, gray};
`else
  assign pixel = {{(2*VEC_W){1'b0}}, gray};
`endif
endmodule

module hw_accel_unpack_rgb_gray #(
  parameter int UNPACK_MODE  = 2,
  parameter int FRAME_WIDTH  = 96,
  parameter int FRAME_HEIGHT = 96
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_packed_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] out_pixel_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_eol,
  output logic        out_eof
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int XW        = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW        = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  typedef struct packed {
    logic [3*VEC_W-1:0] data;
    logic               eol;
    logic               eof;
  } pix_rsp_t;

  logic [NUM_LANES-1:0][VEC_W-1:0]   word_q;
  logic                              full_q;
  logic [1:0]                        slot_q;
  logic [XW-1:0]                     x_q;
  logic [YW-1:0]                     y_q;
  logic [NUM_LANES-1:0][3*VEC_W-1:0] lane_pix;
  logic [3*VEC_W-1:0]                rgb_pix;
  pix_rsp_t                          rsp;
  logic                              last_slot;
  logic                              hs;
  logic                              accept;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hw_accel_unpack_rgb_gray_lane #(.VEC_W(VEC_W)) u_lane (
      .gray  (word_q[l]),
      .pixel (lane_pix[l])
    );
  end

  // Byte 3 never reaches the output in the one-pixel-per-word modes.
  always_comb begin
    rgb_pix = '0;
    if (UNPACK_MODE == 1) rgb_pix = {word_q[2], word_q[1], word_q[0]};
    else                  rgb_pix = {word_q[0], word_q[1], word_q[2]};
  end

  always_comb begin
    rsp      = '0;
    rsp.eol  = full_q && (x_q == X_LAST);
    rsp.eof  = rsp.eol && (y_q == Y_LAST);
    if (full_q) rsp.data = (UNPACK_MODE == 2) ? lane_pix[slot_q] : rgb_pix;
  end

  // The eof pixel also retires its word, so a new frame always begins at slot 0 of a fresh word.
  assign last_slot = (UNPACK_MODE != 2) || (slot_q == 2'd3) || rsp.eof;
  assign hs        = full_q && out_ready;
  assign in_ready  = !full_q || (hs && last_slot);
  assign accept    = in_valid && in_ready;

  assign out_valid      = full_q;
  assign out_pixel_data = rsp.data;
  assign out_eol        = rsp.eol;
  assign out_eof        = rsp.eof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      full_q <= 1'b0;
      slot_q <= 2'd0;
    end else if (accept) begin
      word_q <= in_packed_data;
      full_q <= 1'b1;
      slot_q <= 2'd0;
    end else if (hs && last_slot) begin
      full_q <= 1'b0;
      slot_q <= 2'd0;
    end else if (hs) begin
      slot_q <= slot_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (hs) begin
      if (x_q == X_LAST) begin
        x_q <= '0;
        y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hw_accel_unpack_rgb_gray.sv
// Scoreboard bench: five unpacker configurations, expected pixels queued by stimulus, checked by monitors.
module tb_hw_accel_unpack_rgb_gray;
  localparam int N = 5;
  localparam int MODE [N] = '{2, 2, 0, 1, 2};
  localparam int FW   [N] = '{2, 3, 1, 1, 96};
  localparam int FH   [N] = '{2, 1, 2, 2, 96};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0][31:0] in_data;
  logic [N-1:0][23:0] out_data;
  logic [N-1:0] in_valid, in_ready, out_valid, out_ready, out_eol, out_eof, rdy_set;
  logic tog_en, tog;
  int checks = 0;
  int failures = 0;
  logic [25:0] exp_q [N][$];
  int popped [N] = '{default: 0};

  always #5 clk = ~clk;

  assign out_ready[0]     = tog_en ? tog : rdy_set[0];
  assign out_ready[N-1:1] = rdy_set[N-1:1];

  initial begin
    tog = 1'b0;
    forever begin
      @(posedge clk); #1;
      tog = ~tog;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic        stalled;
    logic [25:0] held, got, e;

    hw_accel_unpack_rgb_gray #(.UNPACK_MODE(MODE[g]), .FRAME_WIDTH(FW[g]), .FRAME_HEIGHT(FH[g])) u_dut (
      .clk            (clk),
      .rst            (rst),
      .in_packed_data (in_data[g]),
      .in_valid       (in_valid[g]),
      .in_ready       (in_ready[g]),
      .out_pixel_data (out_data[g]),
      .out_valid      (out_valid[g]),
      .out_ready      (out_ready[g]),
      .out_eol        (out_eol[g]),
      .out_eof        (out_eof[g])
    );

    initial begin
      stalled = 1'b0;
      held    = '0;
      forever begin
        @(negedge clk);
        got = {out_eol[g], out_eof[g], out_data[g]};
        if (rst) begin
          stalled = 1'b0;
        end else if (!out_valid[g]) begin
          if (stalled) begin
            checks++;
            failures++;
            $display("FAIL valid_dropped inst%0d: out_valid=0 while stalled, required 1", g);
          end
          stalled = 1'b0;
        end else begin
          if (stalled) begin
            checks++;
            if (got !== held) begin
              failures++;
              $display("FAIL stall_hold inst%0d actual=%h required=%h", g, got, held);
            end
          end
          if (out_ready[g]) begin
            checks++;
            stalled = 1'b0;
            popped[g]++;
            if (exp_q[g].size() == 0) begin
              failures++;
              $display("FAIL extra_pixel inst%0d actual={eol,eof,data}=%h required=none", g, got);
            end else begin
              e = exp_q[g].pop_front();
              if (got !== e) begin
                failures++;
                $display("FAIL pixel inst%0d actual={eol,eof,data}=%h required=%h", g, got, e);
              end
            end
          end else begin
            stalled = 1'b1;
            held    = got;
          end
        end
      end
    end
  end

  function automatic logic [23:0] gray_px(input logic [7:0] g);
`ifdef HW_ACCEL_UNPACK_GRAY_EXPAND_EN
    return {g, g, g};
`else
    return {16'd0, g};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic px(input int i, input logic [23:0] d, input logic eol, input logic eof);
    exp_q[i].push_back({eol, eof, d});
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the word, valid left high.
  task automatic send_word(input int i, input logic [31:0] w);
    int n;
    n = 0;
    in_data[i]  = w;
    in_valid[i] = 1'b1;
    @(negedge clk);
    while (!in_ready[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_inst%0d", i), {31'd0, in_ready[i]}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int i, input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (exp_q[i].size() != 0 && n < 400);
    #1;
    check({name, "_drain"}, exp_q[i].size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] w;
  logic [7:0]  b;
  logic        eol, eof;
  int          x, y, n;

  initial begin
    in_data  = '0;
    in_valid = '0;
    rdy_set  = '1;
    tog_en   = 1'b0;
    #3;
    check("rst_out_valid", {27'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {27'd0, in_ready},  32'h1f);
    check("rst_eol_eof",   {22'd0, out_eol, out_eof}, 32'd0);
    check("rst_data0",     {8'd0, out_data[0]}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 2x2 gray frame from one word
    px(0, gray_px(8'h11), 0, 0); px(0, gray_px(8'h22), 1, 0);
    px(0, gray_px(8'h33), 0, 0); px(0, gray_px(8'h44), 1, 1);
    send_word(0, 32'h44332211);
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("t1_in_ready_slot0", {31'd0, in_ready[0]}, 32'd0);
    repeat (3) @(negedge clk);
    check("t1_in_ready_slot3", {31'd0, in_ready[0]}, 32'd1);
    check("t1_eof_slot3",      {31'd0, out_eof[0]},  32'd1);
    @(posedge clk); #1;
    drain(0, "t1");

    // Alternating backpressure across two back-to-back words
    for (int k = 0; k < 8; k++) px(0, gray_px(8'(k)), (k % 2) == 1, (k % 4) == 3);
    tog_en = 1'b1;
    send_word(0, 32'h03020100);
    send_word(0, 32'h07060504);
    in_valid[0] = 1'b0;
    drain(0, "t2");
    tog_en = 1'b0;

    // 3x1 frame: slot 3 of the first word is flushed at eof
    px(1, gray_px(8'hAA), 0, 0); px(1, gray_px(8'hBB), 0, 0); px(1, gray_px(8'hCC), 1, 1);
    px(1, gray_px(8'h11), 0, 0); px(1, gray_px(8'h22), 0, 0); px(1, gray_px(8'h33), 1, 1);
    send_word(1, 32'hDDCCBBAA);
    send_word(1, 32'h44332211);
    in_valid[1] = 1'b0;
    drain(1, "t3");
    repeat (3) @(negedge clk);
    check("t3_no_flushed_pixel", {31'd0, out_valid[1]}, 32'd0);
    @(posedge clk); #1;

    // RGB modes, one pixel per word, width 1
    px(2, 24'h112233, 1, 0); px(2, 24'hAABBCC, 1, 1);
    px(3, 24'h332211, 1, 0); px(3, 24'hCCBBAA, 1, 1);
    send_word(2, 32'h00332211);
    send_word(2, 32'hFFCCBBAA);
    in_valid[2] = 1'b0;
    send_word(3, 32'h00332211);
    send_word(3, 32'hFFCCBBAA);
    in_valid[3] = 1'b0;
    drain(2, "t4_mode0");
    drain(3, "t4_mode1");

    // Reset mid-frame on the 96x96 instance after five pixels
    for (int k = 0; k < 8; k++) px(4, gray_px(8'(k + 1)), 0, 0);
    send_word(4, 32'h04030201);
    send_word(4, 32'h08070605);
    in_valid[4] = 1'b0;
    n = 0;
    while (popped[4] < 5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_five_popped", popped[4], 32'd5);
    rst = 1'b1;
    #1;
    check("t5_rst_valid",    {31'd0, out_valid[4]}, 32'd0);
    check("t5_rst_data",     {8'd0, out_data[4]},   32'd0);
    check("t5_rst_eol_eof",  {30'd0, out_eol[4], out_eof[4]}, 32'd0);
    check("t5_rst_in_ready", {31'd0, in_ready[4]},  32'd1);
    exp_q[4].delete();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Full 96x96 frame: eof must land on handshake 9216 and nowhere else
    x = 0; y = 0;
    for (int k = 0; k < 2304; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        b   = 8'(4 * k + j + 1);
        eol = (x == 95);
        eof = eol && (y == 95);
        px(4, gray_px(b), eol, eof);
        w[8*j +: 8] = b;
        if (eol) begin
          x = 0;
          y = (y == 95) ? 0 : y + 1;
        end else begin
          x++;
        end
      end
      send_word(4, w);
    end
    in_valid[4] = 1'b0;
    drain(4, "t5_frame");

    // Gray expansion option on a fresh frame
    px(4, gray_px(8'hA5), 0, 0);
    px(4, gray_px(8'h00), 0, 0); px(4, gray_px(8'h00), 0, 0); px(4, gray_px(8'h00), 0, 0);
    send_word(4, 32'h000000A5);
    in_valid[4] = 1'b0;
    drain(4, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
